// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and divider helper for the configurable UART receiver
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Rounded clocks per oversampling tick.
  function automatic int calc_div(input int clk_hz, input int baud_rate, input int oversample);
    int den;
    den = baud_rate * oversample;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead receive FIFO, head entry visible on rdata_o
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised UART receiver with majority voting, break detect and FIFO
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rxd_i,
  input  logic                          rd_i,
  input  logic                          err_clr_i,
  output logic [DATA_BITS-1:0]          data_o,
  output logic                          valid_o,
  output logic                          ferr_o,
  output logic                          perr_o,
  output logic                          oerr_o,
  output logic                          brk_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int      DIV      = calc_div(CLK_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int      DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int      OS_W     = $clog2(OVERSAMPLE);
  localparam int      BIT_W    = $clog2(DATA_BITS + 1);
  localparam parity_t PAR_MODE = parity_t'(PARITY);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  SMP0     = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  SMP1     = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  SMP2     = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);

  logic                   rxd_meta_q, rxd_s_q, rxd_prev_q;
  rx_state_t              state_q;
  logic [DIV_W-1:0]       div_cnt_q;
  logic [OS_W-1:0]        os_cnt_q;
  logic [BIT_W-1:0]       bit_cnt_q;
  logic [1:0]             smp_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_bit_q, perr_q, ferr_q;
  logic                   push_q, oerr_q, brk_q;
  logic [DATA_BITS+1:0]   wdata_q, head;
  logic                   tick, maj, at_maj, at_end, start_edge, ferr_d, is_break;
  logic                   fifo_full, fifo_empty, pop;

  assign tick       = (div_cnt_q == DIV_LAST);
  assign maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_s_q) | (smp_q[1] & rxd_s_q);
  assign at_maj     = tick && (os_cnt_q == SMP2);
  assign at_end     = tick && (os_cnt_q == OS_LAST);
  assign start_edge = (state_q == ST_IDLE) && rxd_prev_q && !rxd_s_q;
  assign ferr_d     = ferr_q | ~maj;
  assign is_break   = (shift_q == '0) && ((PAR_MODE == PAR_NONE) || !par_bit_q) && !maj;
  assign pop        = rd_i && !fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd_i;
      rxd_s_q    <= rxd_meta_q;
      rxd_prev_q <= rxd_s_q;
    end
  end

  // Restarting the divider on the start edge centres the sample window on each bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 div_cnt_q <= '0;
    else if (start_edge || tick) div_cnt_q <= '0;
    else                         div_cnt_q <= div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      smp_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      push_q    <= 1'b0;
      wdata_q   <= '0;
      oerr_q    <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (err_clr_i) begin
        oerr_q <= 1'b0;
        brk_q  <= 1'b0;
      end
      if (push_q && fifo_full && !pop) oerr_q <= 1'b1;
      if (tick) begin
        if (os_cnt_q == SMP0) smp_q[0] <= rxd_s_q;
        if (os_cnt_q == SMP1) smp_q[1] <= rxd_s_q;
        os_cnt_q <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
      end
      case (state_q)
        ST_IDLE: if (start_edge) begin
          state_q   <= ST_START;
          os_cnt_q  <= '0;
          bit_cnt_q <= '0;
          ferr_q    <= 1'b0;
          perr_q    <= 1'b0;
        end
        ST_START: begin
          if (at_maj && maj) state_q <= ST_IDLE;
          else if (at_end)   state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (at_maj) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
          if (at_end) begin
            if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (at_maj) begin
            par_bit_q <= maj;
            perr_q    <= ((^shift_q) ^ maj) != (PAR_MODE == PAR_ODD);
          end
          if (at_end) state_q <= ST_STOP;
        end
        ST_STOP: begin
          // Commit at the last stop bit's vote; the rest of that bit is left for resync.
          if (at_maj) begin
            ferr_q <= ferr_d;
            if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
              if (is_break) begin
                brk_q   <= 1'b1;
                state_q <= ST_BREAK;
              end else begin
                push_q  <= 1'b1;
                wdata_q <= {shift_q, ferr_d, perr_q};
                state_q <= ST_IDLE;
              end
            end
          end
          if (at_end) bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        ST_BREAK: if (rxd_s_q) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_q),
    .wdata_i (wdata_q),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  assign valid_o = !fifo_empty;
  assign {data_o, ferr_o, perr_o} = valid_o ? head : '0;
  assign oerr_o  = oerr_q;
  assign brk_o   = brk_q;

endmodule
